minisrc_jump_ctrl: RTL

Hardwired control sequencer for the Mini SRC datapath. It generates the instruction-fetch step signals (T0–T2) and the execute steps for the jump/control instruction class (jr, jal, nop, halt), one step per clock. It replaces hand-driven control sequences with a parametrised state machine that supports a configurable memory wait and a run/halt handshake. It sits beside `datapath` and drives its control inputs directly.

---
 rtl/minisrc_jump_ctrl.sv | 182 ++++++++++++++++++
 1 files changed

// File: rtl/minisrc_jump_ctrl.sv
// Hardwired fetch/execute sequencer for the Mini SRC jump/control class (jr, jal, nop, halt).
// Define MINISRC_JAL_EN to enable jal decode and the T4 link step.
module minisrc_jump_ctrl #(
   parameter int IR_W     = 32,
   parameter int OPC_W    = 5,
   parameter int MEM_WAIT = 0,
   parameter int WAIT_W   = 4
) (
   input  logic            clk,
   input  logic            clr,
   input  logic            start,
   input  logic [IR_W-1:0] ir_data,
   output logic            pc_out,
   output logic            mar_in,
   output logic            inc_pc,
   output logic            z_in,
   output logic            zlow_out,
   output logic            pc_in,
   output logic            read,
   output logic            mdr_in,
   output logic            mdr_out,
   output logic            ir_in,
   output logic            gra,
   output logic            rout,
   output logic            rin,
   output logic            link_sel,
   output logic            run,
   output logic            illegal,
   output logic [2:0]      step
);

   localparam logic [2:0] S_T0    = 3'd0;
   localparam logic [2:0] S_T1    = 3'd1;
   localparam logic [2:0] S_T2    = 3'd2;
   localparam logic [2:0] S_T3    = 3'd3;
   localparam logic [2:0] S_T4    = 3'd4;
   localparam logic [2:0] S_HALT  = 3'd5;
   localparam logic [2:0] S_RESET = 3'd7;

   localparam logic [OPC_W-1:0] OP_JR   = OPC_W'(5'b10100);
   localparam logic [OPC_W-1:0] OP_NOP  = OPC_W'(5'b11010);
   localparam logic [OPC_W-1:0] OP_HALT = OPC_W'(5'b11011);
`ifdef MINISRC_JAL_EN
   localparam logic [OPC_W-1:0] OP_JAL  = OPC_W'(5'b10011);
`endif

   localparam logic [WAIT_W-1:0] WAIT_INIT = WAIT_W'(MEM_WAIT);

   logic [2:0]       state, state_nxt;
   logic [WAIT_W-1:0] wait_cnt, wait_nxt;
   logic             illegal_nxt;
   logic [OPC_W-1:0] opcode;
   logic             op_jr, op_jal, op_nop, op_halt, op_known;
   logic             t1_first;
   logic             unused_ir_bits;

   assign opcode = ir_data[IR_W-1 -: OPC_W];
   // Operand fields belong to the datapath; only the opcode is decoded here.
   assign unused_ir_bits = ^ir_data[IR_W-OPC_W-1:0];

   assign op_jr   = (opcode == OP_JR);
   assign op_nop  = (opcode == OP_NOP);
   assign op_halt = (opcode == OP_HALT);
`ifdef MINISRC_JAL_EN
   assign op_jal  = (opcode == OP_JAL);
`else
   assign op_jal  = 1'b0;
`endif
   assign op_known = op_jr | op_jal | op_nop | op_halt;

   // The counter is reloaded on T1 entry, so it equals MEM_WAIT only in the first T1 cycle.
   assign t1_first = (wait_cnt == WAIT_INIT);

   always_comb begin
      state_nxt   = state;
      wait_nxt    = wait_cnt;
      illegal_nxt = illegal;
      case (state)
         S_RESET: state_nxt = S_T0;
         S_T0: begin
            state_nxt = S_T1;
            wait_nxt  = WAIT_INIT;
         end
         S_T1: begin
            if (wait_cnt == '0) state_nxt = S_T2;
            else                wait_nxt  = wait_cnt - WAIT_W'(1);
         end
         S_T2: state_nxt = S_T3;
         S_T3: begin
            if (op_jal)       state_nxt = S_T4;
            else if (op_halt) state_nxt = S_HALT;
            else              state_nxt = S_T0;
            if (!op_known) illegal_nxt = 1'b1;
         end
`ifdef MINISRC_JAL_EN
         S_T4: state_nxt = S_T0;
`endif
         S_HALT: begin
            if (start) begin
               state_nxt   = S_T0;
               illegal_nxt = 1'b0;
            end
         end
         default: state_nxt = S_RESET;
      endcase
   end

   always_ff @(posedge clk or negedge clr) begin
      if (!clr) begin
         state    <= S_RESET;
         wait_cnt <= '0;
         illegal  <= 1'b0;
      end else begin
         state    <= state_nxt;
         wait_cnt <= wait_nxt;
         illegal  <= illegal_nxt;
      end
   end

   always_comb begin
      pc_out   = 1'b0;
      mar_in   = 1'b0;
      inc_pc   = 1'b0;
      z_in     = 1'b0;
      zlow_out = 1'b0;
      pc_in    = 1'b0;
      read     = 1'b0;
      mdr_in   = 1'b0;
      mdr_out  = 1'b0;
      ir_in    = 1'b0;
      gra      = 1'b0;
      rout     = 1'b0;
      rin      = 1'b0;
      link_sel = 1'b0;
      run      = 1'b1;
      step     = state;
      case (state)
         S_T0: begin
            pc_out = 1'b1;
            mar_in = 1'b1;
            inc_pc = 1'b1;
            z_in   = 1'b1;
         end
         S_T1: begin
            read     = 1'b1;
            mdr_in   = 1'b1;
            zlow_out = t1_first;
            pc_in    = t1_first;
         end
         S_T2: begin
            mdr_out = 1'b1;
            ir_in   = 1'b1;
         end
         S_T3: begin
            if (op_jr) begin
               gra   = 1'b1;
               rout  = 1'b1;
               pc_in = 1'b1;
            end
`ifdef MINISRC_JAL_EN
            else if (op_jal) begin
               pc_out   = 1'b1;
               rin      = 1'b1;
               link_sel = 1'b1;
            end
`endif
         end
`ifdef MINISRC_JAL_EN
         S_T4: begin
            gra   = 1'b1;
            rout  = 1'b1;
            pc_in = 1'b1;
         end
`endif
         default: begin
            run  = 1'b0;
            step = 3'd7;
         end
      endcase
   end

endmodule
